score_tracker: RTL and testbench
================================

SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 50_000_000, giving the number of clk cycles the SHOW state lasts.
REQ-002 The module SHALL have parameter BLINK_CYCLES, default 12_500_000, giving the half-period in clk cycles of the new-best blink.
REQ-003 Port clk  input  1  single system clock; all logic on posedge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port score_valid  input  1  one-cycle pulse: a round finished and score_a/b/c are stable.
REQ-006 Port score_a, score_b, score_c  input  4 each  BCD ms digits (ones, tens, hundreds).
REQ-007 Port show_best  input  1  display select: 1 = best time, 0 = last time.
REQ-008 Port disp_a, disp_b, disp_c  output  4 each  BCD digits for the downstream HEX decoders.
REQ-009 Port attempts  output  8  two-digit BCD count of accepted rounds, tens in [7:4].
REQ-010 Port new_best  output  1  one-cycle pulse when best is updated.
REQ-011 Port LEDR  output  10  status LEDs.
REQ-012 Port busy  output  1  high in COMPARE and SHOW.
REQ-013 Port err  output  1  sticky flag: invalid BCD digit or overrun.

Function
REQ-014 The FSM SHALL have states IDLE, COMPARE, SHOW, encoded in a 2-bit register.
REQ-015 In IDLE, a score_valid pulse SHALL latch score_a/b/c into last_a/b/c and move to COMPARE on the next edge.
REQ-016 If any latched digit is greater than 9, COMPARE SHALL set err, leave best and attempts unchanged, and return to IDLE.
REQ-017 COMPARE SHALL order times by hundreds digit, then tens, then ones.
REQ-018 COMPARE SHALL copy last into best and pulse new_best for exactly one cycle when attempts is 00 or last is strictly less than best; equal times SHALL NOT update best.
REQ-019 COMPARE SHALL increment attempts as a BCD value, saturating at 99; digits SHALL never leave 0-9.
REQ-020 COMPARE SHALL last exactly one cycle, then enter SHOW; new_best SHALL be asserted in the cycle SHOW is entered.
REQ-021 SHOW SHALL last exactly HOLD_CYCLES cycles, then return to IDLE.
REQ-022 A score_valid pulse during COMPARE or SHOW SHALL be dropped and SHALL set err.
REQ-023 disp_a/b/c SHALL show best when show_best=1, otherwise last; this selection is combinational from registered values.
REQ-024 Before the first accepted round, disp_a/b/c SHALL read 0/0/0 for both best and last.
REQ-025 LEDR[9] SHALL equal busy, LEDR[8] SHALL equal err, and LEDR[7:0] SHALL equal attempts.
REQ-026 A score_valid pulse in the same cycle that SHOW returns to IDLE SHALL be dropped, because the state is not yet IDLE.

Reset
REQ-027 While rst=1 at a clk edge, state SHALL be IDLE, and last, best, attempts, err, new_best, the hold counter and the blink counter SHALL all be 0.
REQ-028 Reset SHALL take priority over score_valid and over any in-progress COMPARE or SHOW, which are abandoned.

Configuration
REQ-029 With SCORE_TRACKER_BLINK_EN defined, in SHOW after a new best, disp_a/b/c SHALL toggle between best and 0xF (blank) every BLINK_CYCLES, starting visible.
REQ-030 With SCORE_TRACKER_BLINK_EN undefined, no blink counter SHALL exist, BLINK_CYCLES SHALL be unused, and the display SHALL follow REQ-023 only.

Structure
REQ-031 A shared package SHALL hold the state encoding constants (ST_IDLE=0, ST_COMPARE=1, ST_SHOW=2), the BCD blank code 4'hF and the 3-digit BCD time type.
REQ-032 One sub-module, bcd_time_lt, SHALL implement the combinational 3-digit strict less-than used by COMPARE.

Verification
REQ-033 Reset, then send score 2/5/3 (352 ms) -> attempts=0x01, best=352, new_best pulses once, busy for HOLD_CYCLES+1 cycles.
REQ-034 After 352, send 9/9/2 (299) -> best=299 and new_best pulses; then send 299 again -> best unchanged, no new_best, attempts=0x03.
REQ-035 Send digit score_a=4'hA -> err=1, attempts unchanged, FSM back in IDLE after 1 cycle.
REQ-036 Send score_valid mid-SHOW -> err=1 and the pulse is ignored; also drive 100 valid rounds -> attempts saturates at 0x99.
REQ-037 Assert rst in mid-SHOW -> next cycle IDLE with all outputs 0; with SCORE_TRACKER_BLINK_EN and HOLD_CYCLES=8, BLINK_CYCLES=2 -> display pattern is visible, visible, F, F, visible, visible, F, F.

Source files
------------

// File: rtl/score_tracker_pkg.sv
// Shared types for the score tracker: FSM states, BCD time, helpers.
// Optional display blink is enabled with SCORE_TRACKER_BLINK_EN.
package score_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_SHOW    = 2'd2
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] c;
    logic [3:0] b;
    logic [3:0] a;
  } bcd_time_t;

  function automatic logic bcd_time_ok(bcd_time_t t);
    return (t.a <= 4'd9) && (t.b <= 4'd9) && (t.c <= 4'd9);
  endfunction

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/score_tracker_bcd_time_lt.sv
// Strict less-than for 3-digit BCD times.
// Compared hundreds first, then tens, then ones.
module bcd_time_lt
  import score_tracker_pkg::*;
(
  input  logic [11:0] lhs_i,
  input  logic [11:0] rhs_i,
  output logic        lt_o
);

  bcd_time_t l;
  bcd_time_t r;

  assign l = lhs_i;
  assign r = rhs_i;

  always_comb begin
    lt_o = 1'b0;
    if (l.c != r.c)
      lt_o = l.c < r.c;
    else if (l.b != r.b)
      lt_o = l.b < r.b;
    else
      lt_o = l.a < r.a;
  end

endmodule

// File: rtl/score_tracker.sv
// Reaction-time score tracker: keeps last/best BCD time and attempt count.
// Define SCORE_TRACKER_BLINK_EN to blink a new best during SHOW.
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_valid,
  input  logic [3:0] score_a,
  input  logic [3:0] score_b,
  input  logic [3:0] score_c,
  input  logic       show_best,
  output logic [3:0] disp_a,
  output logic [3:0] disp_b,
  output logic [3:0] disp_c,
  output logic [7:0] attempts,
  output logic       new_best,
  output logic [9:0] LEDR,
  output logic       busy,
  output logic       err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_e         state_q;
  bcd_time_t      last_q;
  bcd_time_t      best_q;
  logic [7:0]     att_q;
  logic           err_q;
  logic           nb_q;
  logic [HW-1:0]  hold_q;
  logic           last_lt_best;
  bcd_time_t      disp_d;

  bcd_time_lt u_lt (
    .lhs_i (last_q),
    .rhs_i (best_q),
    .lt_o  (last_lt_best)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      best_q  <= '0;
      att_q   <= '0;
      err_q   <= 1'b0;
      nb_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      nb_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (score_valid) begin
            last_q  <= {score_c, score_b, score_a};
            state_q <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (score_valid)
            err_q <= 1'b1;
          if (!bcd_time_ok(last_q)) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            // Attempts of 00 means no best exists yet.
            if (att_q == 8'h00 || last_lt_best) begin
              best_q <= last_q;
              nb_q   <= 1'b1;
            end
            att_q   <= bcd_inc_sat(att_q);
            hold_q  <= '0;
            state_q <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (score_valid)
            err_q <= 1'b1;
          if (hold_q == HOLD_LAST)
            state_q <= ST_IDLE;
          else
            hold_q <= hold_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SCORE_TRACKER_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_q;
  logic          blank_q;
  logic          blink_on_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q    <= '0;
      blank_q    <= 1'b0;
      blink_on_q <= 1'b0;
    end else if (state_q == ST_COMPARE) begin
      blink_q    <= '0;
      blank_q    <= 1'b0;
      blink_on_q <= bcd_time_ok(last_q) &&
                    (att_q == 8'h00 || last_lt_best);
    end else if (state_q == ST_SHOW) begin
      if (blink_q == BLINK_LAST) begin
        blink_q <= '0;
        blank_q <= ~blank_q;
      end else begin
        blink_q <= blink_q + 1'b1;
      end
    end
  end

  always_comb begin
    disp_d = show_best ? best_q : last_q;
    if (state_q == ST_SHOW && blink_on_q)
      disp_d = blank_q ? {3{BCD_BLANK}} : best_q;
  end
`else
  always_comb begin
    disp_d = show_best ? best_q : last_q;
  end
`endif

  assign disp_a   = disp_d.a;
  assign disp_b   = disp_d.b;
  assign disp_c   = disp_d.c;
  assign attempts = att_q;
  assign new_best = nb_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign LEDR     = {busy, err_q, att_q};

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed tables plus a
// randomized run against a millisecond-level reference model.
module tb_score_tracker;

  localparam int HOLD  = 8;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       score_valid = 1'b0;
  logic [3:0] score_a = '0;
  logic [3:0] score_b = '0;
  logic [3:0] score_c = '0;
  logic       show_best = 1'b0;
  logic [3:0] disp_a, disp_b, disp_c;
  logic [7:0] attempts;
  logic       new_best;
  logic [9:0] LEDR;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  score_tracker #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
    .clk         (clk),
    .rst         (rst),
    .score_valid (score_valid),
    .score_a     (score_a),
    .score_b     (score_b),
    .score_c     (score_c),
    .show_best   (show_best),
    .disp_a      (disp_a),
    .disp_b      (disp_b),
    .disp_c      (disp_c),
    .attempts    (attempts),
    .new_best    (new_best),
    .LEDR        (LEDR),
    .busy        (busy),
    .err         (err)
  );

  // Reference model: times as plain digit arrays / milliseconds.
  int m_last [3];
  int m_best [3];
  int m_att  = 0;
  bit m_err  = 0;
  bit m_nb   = 0;
  bit m_cmp  = 0;
  int m_left = 0;
  bit m_blink = 0;

  function automatic int ms(int d [3]);
    return d[2] * 100 + d[1] * 10 + d[0];
  endfunction

  task automatic model_step();
    if (rst) begin
      foreach (m_last[i]) begin m_last[i] = 0; m_best[i] = 0; end
      m_att = 0; m_err = 0; m_nb = 0; m_cmp = 0; m_left = 0;
      m_blink = 0;
      return;
    end
    m_nb = 0;
    if (m_cmp) begin
      m_cmp = 0;
      if (score_valid) m_err = 1;
      if (m_last[0] > 9 || m_last[1] > 9 || m_last[2] > 9) begin
        m_err = 1;
      end else begin
        m_blink = 0;
        if (m_att == 0 || ms(m_last) < ms(m_best)) begin
          m_best = m_last;
          m_nb = 1;
          m_blink = 1;
        end
        if (m_att < 99) m_att++;
        m_left = HOLD;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (score_valid) m_err = 1;
    end else if (score_valid) begin
      m_last[0] = score_a; m_last[1] = score_b; m_last[2] = score_c;
      m_cmp = 1;
    end
  endtask

  function automatic logic [32:0] model_vec();
    logic [11:0] d;
    logic [7:0]  a;
    bit          bz;
    d = show_best ? 12'(m_best[2] * 256 + m_best[1] * 16 + m_best[0])
                  : 12'(m_last[2] * 256 + m_last[1] * 16 + m_last[0]);
`ifdef SCORE_TRACKER_BLINK_EN
    if (m_left > 0 && m_blink) begin
      if (((HOLD - m_left) / BLINK) % 2 == 1)
        d = 12'hFFF;
      else
        d = 12'(m_best[2] * 256 + m_best[1] * 16 + m_best[0]);
    end
`endif
    a  = 8'((m_att / 10) * 16 + (m_att % 10));
    bz = m_cmp || (m_left > 0);
    return {d, a, m_nb, bz, m_err, bz, m_err, a};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {disp_c, disp_b, disp_a, attempts, new_best, busy, err, LEDR};
  endfunction

  task automatic chk(string name, logic [32:0] got, logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_round(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c,
                          output int busy_cyc, output int nb_cnt);
    score_a = a; score_b = b; score_c = c;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    busy_cyc = 0;
    nb_cnt = 0;
    for (int i = 0; i < HOLD + 6; i++) begin
      if (!busy) break;
      busy_cyc++;
      nb_cnt += int'(new_best);
      tick();
    end
  endtask

  typedef struct {
    logic [3:0]  a, b, c;
    logic [11:0] exp_best;
    logic [7:0]  exp_att;
    int          exp_nb;
  } round_t;

  round_t rounds [5];
  int bc, nc;

  initial begin
    rounds[0] = '{4'd2, 4'd5, 4'd3, 12'h352, 8'h01, 1};
    rounds[1] = '{4'd9, 4'd9, 4'd2, 12'h299, 8'h02, 1};
    rounds[2] = '{4'd9, 4'd9, 4'd2, 12'h299, 8'h03, 0};
    rounds[3] = '{4'd0, 4'd0, 4'd4, 12'h299, 8'h04, 0};
    rounds[4] = '{4'd9, 4'd9, 4'd1, 12'h199, 8'h05, 1};

    do_reset();
    chk("reset_outs", dut_vec(), 33'h0);

    show_best = 1'b1;
    foreach (rounds[i]) begin
      do_round(rounds[i].a, rounds[i].b, rounds[i].c, bc, nc);
      chk("busy_len", 33'(bc), 33'(HOLD + 1));
      chk("nb_pulses", 33'(nc), 33'(rounds[i].exp_nb));
      chk("best", 33'({disp_c, disp_b, disp_a}), 33'(rounds[i].exp_best));
      chk("attempts", 33'(attempts), 33'(rounds[i].exp_att));
    end

    // Invalid digit: err set, count kept, one-cycle COMPARE.
    score_a = 4'hA; score_b = 4'd1; score_c = 4'd1;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    tick();
    chk("bad_err", 33'(err), 33'd1);
    chk("bad_idle", 33'(busy), 33'd0);
    chk("bad_att", 33'(attempts), 33'h05);

    // Pulse during SHOW is dropped and flags err.
    do_reset();
    score_a = 4'd1; score_b = 4'd2; score_c = 4'd3;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    tick(); tick();
    score_a = 4'd0; score_b = 4'd0; score_c = 4'd1;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    chk("show_err", 33'(err), 33'd1);
    for (int i = 0; i < HOLD + 4; i++) tick();
    chk("show_att", 33'(attempts), 33'h01);
    show_best = 1'b0;
    chk("show_last", 33'({disp_c, disp_b, disp_a}), 33'h321);

    // Pulse exactly when SHOW ends is dropped too.
    do_reset();
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    for (int i = 0; i < HOLD; i++) tick();
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    tick();
    chk("edge_drop_busy", 33'(busy), 33'd0);
    chk("edge_drop_err", 33'(err), 33'd1);

    // Reset mid-SHOW clears everything.
    do_reset();
    score_a = 4'd5; score_b = 4'd5; score_c = 4'd5;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    tick(); tick(); tick();
    do_reset();
    chk("rst_show", dut_vec(), 33'h0);

`ifdef SCORE_TRACKER_BLINK_EN
    begin
      logic [11:0] pat [8];
      pat = '{12'h352, 12'h352, 12'hFFF, 12'hFFF,
              12'h352, 12'h352, 12'hFFF, 12'hFFF};
      show_best = 1'b0;
      score_a = 4'd2; score_b = 4'd5; score_c = 4'd3;
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
        chk("blink", 33'({disp_c, disp_b, disp_a}), 33'(pat[i]));
        tick();
      end
      do_reset();
    end
`endif

    // Saturation after 100 accepted rounds.
    for (int r = 0; r < 100; r++)
      do_round(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), bc, nc);
    chk("saturate", 33'(attempts), 33'h99);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      score_valid = ($urandom_range(0, 5) == 0);
      score_a = ($urandom_range(0, 15) == 0) ? 4'hC : 4'($urandom_range(0, 9));
      score_b = 4'($urandom_range(0, 9));
      score_c = 4'($urandom_range(0, 9));
      show_best = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;
    score_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
